// File: rtl/hier_fanin_arb.sv
// Multi-channel FIFO fan-in with round-robin arbitration into a registered output stage.
// Optional per-channel grant counters are enabled by defining HIER_FANIN_ARB_STATS_EN.
module hier_fanin_arb #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
`ifdef HIER_FANIN_ARB_STATS_EN
  output logic [NUM_CH*16-1:0]     grant_cnt,
`endif
  input  logic                     out_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];
  logic [CNT_W-1:0]  cnt    [NUM_CH];

  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   gnt;
  logic [DATA_W-1:0] head_data;
  logic              found;
  logic              load;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      in_ready[c] = (cnt[c] != CNT_W'(DEPTH));
      nonempty[c] = (cnt[c] != '0);
    end
  end

  assign push = in_valid & in_ready;
  assign load = !out_valid || out_ready;

  // Two-pass search: channels above last_grant first, then wrap to the lowest.
  always_comb begin
    logic          hi_found, lo_found;
    logic [CH_W-1:0] hi_gnt, lo_gnt;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_gnt   = '0;
    lo_gnt   = '0;
    found    = 1'b0;
    gnt      = '0;
    if (NUM_CH == 1) begin
      found = nonempty[0];
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!hi_found && nonempty[c] && (c > int'(last_grant))) begin
          hi_found = 1'b1;
          hi_gnt   = CH_W'(c);
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (!lo_found && nonempty[c]) begin
          lo_found = 1'b1;
          lo_gnt   = CH_W'(c);
        end
      end
      found = hi_found || lo_found;
      gnt   = hi_found ? hi_gnt : lo_gnt;
    end
  end

  always_comb begin
    head_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c] = load && found && (gnt == CH_W'(c));
      if (gnt == CH_W'(c)) head_data = mem[c][rd_ptr[c]];
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= in_data[c*DATA_W +: DATA_W];
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        if (push[c] && !pop[c])      cnt[c] <= cnt[c] + 1'b1;
        else if (!push[c] && pop[c]) cnt[c] <= cnt[c] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
    end else if (load) begin
      out_valid <= found;
      if (found) begin
        out_data   <= head_data;
        out_ch     <= gnt;
        last_grant <= gnt;
      end
    end
  end

`ifdef HIER_FANIN_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (out_valid && out_ready) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ((out_ch == CH_W'(c)) && (grant_cnt[c*16 +: 16] != 16'hFFFF))
          grant_cnt[c*16 +: 16] <= grant_cnt[c*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hier_fanin_arb.sv
// Scoreboard bench for hier_fanin_arb: stimulus queues expected {ch,data}, a monitor pops on handshakes.
module tb_hier_fanin_arb;
  localparam int NUM_CH = 5;
  localparam int DATA_W = 8;
  localparam int CH_W   = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_ready;
`ifdef HIER_FANIN_ARB_STATS_EN
  logic [NUM_CH*16-1:0]     grant_cnt;
`endif

  hier_fanin_arb #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
`ifdef HIER_FANIN_ARB_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .out_ready(out_ready));

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int hs_cnt = 0;
  bit sb_en  = 1'b1;
  logic [CH_W+DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int ch, input logic [7:0] d);
    in_valid[ch] = 1'b1;
    in_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic expect_word(input int ch, input logic [7:0] d);
    exp_q.push_back({CH_W'(ch), d});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: outputs are sampled on the falling edge, ahead of the edge that completes the handshake.
  initial begin
    logic [CH_W+DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        hs_cnt++;
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", {out_ch, out_data}, 32'hDEAD);
          end else begin
            e = exp_q.pop_front();
            check("sb_word", {out_ch, out_data}, e);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_base, vcount;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;

    // reset
    do_reset();
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 5'h1F);
    tick();
    check("release_in_ready", in_ready, 5'h1F);

    // single word, one-cycle latency
    out_ready = 1'b1;
    offer(2, 8'hA5);
    expect_word(2, 8'hA5);
    tick();
    in_valid = '0;
    check("lat_not_yet", out_valid, 0);
    tick();
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 8'hA5);
    check("lat_ch", out_ch, 2);
    wait_drain("single_drain", 10);

    // round robin from a fresh reset: channel 0 first
    out_ready = 1'b0;
    do_reset();
    for (int c = 0; c < NUM_CH; c++) offer(c, 8'(c * 16));
    tick();
    for (int c = 0; c < NUM_CH; c++) offer(c, 8'(c * 16 + 1));
    tick();
    in_valid = '0;
    for (int n = 0; n < 2; n++)
      for (int c = 0; c < NUM_CH; c++) expect_word(c, 8'(c * 16 + n));
    hs_base = hs_cnt;
    out_ready = 1'b1;
    repeat (10) tick();
    check("rr_throughput", hs_cnt - hs_base, 10);
    check("rr_idle_after", out_valid, 0);
    check("rr_drain", exp_q.size(), 0);

    // backpressure: output holds ch3, ch0 fills its FIFO
    out_ready = 1'b0;
    offer(3, 8'h3C);
    tick();
    in_valid = '0;
    tick();
    check("bp_loaded", {out_valid, out_ch, out_data}, {1'b1, 3'd3, 8'h3C});
    for (int w = 1; w <= 4; w++) begin
      offer(0, 8'(w));
      tick();
    end
    check("bp_full", in_ready[0], 0);
    offer(0, 8'h05);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold", {in_ready[0], out_valid, out_ch, out_data}, {1'b0, 1'b1, 3'd3, 8'h3C});
    end
    in_valid = '0;
    expect_word(3, 8'h3C);
    for (int w = 1; w <= 4; w++) expect_word(0, 8'(w));
    out_ready = 1'b1;
    wait_drain("bp_drain", 20);
    tick();
    check("bp_idle_after", out_valid, 0);

    // mid-operation reset discards queued words
    out_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      offer(1, 8'(8'h11 + w));
      tick();
    end
    in_valid = '0;
    tick();
    check("mid_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", out_valid, 0);
    rst_n = 1'b1;
    tick();
    check("mid_in_ready", in_ready, 5'h1F);
    out_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) vcount++;
    end
    check("mid_no_words", vcount, 0);

`ifdef HIER_FANIN_ARB_STATS_EN
    for (int w = 0; w < 3; w++) begin
      offer(1, 8'(8'h70 + w));
      expect_word(1, 8'(8'h70 + w));
      tick();
    end
    in_valid = '0;
    wait_drain("stats_drain", 20);
    tick();
    check("stats_ch1", grant_cnt[16 +: 16], 3);
    check("stats_others", {grant_cnt[0 +: 16], grant_cnt[32 +: 48]}, 0);
    sb_en = 1'b0;
    offer(0, 8'h55);
    repeat (65540) tick();
    check("stats_sat", grant_cnt[0 +: 16], 16'hFFFF);
    repeat (4) tick();
    in_valid = '0;
    repeat (3) tick();
    check("stats_sat_hold", grant_cnt[0 +: 16], 16'hFFFF);
    check("stats_ch1_keep", grant_cnt[16 +: 16], 3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
